// File: rtl/cpu_pkg.sv
// Shared RV32I encodings for the cpu_core slice: opcodes, funct3 codes,
// ALU operation enum, load/store size encodings and the ALU evaluation helper.
package cpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3[1:0] of loads/stores; funct3[2] marks zero-extending loads
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    function automatic logic [31:0] alu_exec(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = a + b;
        case (op)
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'b0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear, x0 never written so it always reads zero.
module cpu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] internalRegisters [0:31];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    internalRegisters[gi] <= 32'h0;
                else if (we && waddr == 5'(gi) && waddr != 5'd0)
                    internalRegisters[gi] <= wdata;
            end
        end
    endgenerate

    assign rdata1 = internalRegisters[raddr1];
    assign rdata2 = internalRegisters[raddr2];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I core: one instruction per clk from combinational imem.
// Optional CPU_HALT_ON_ZERO_EN: an all-zero instruction word halts until reset.
module cpu_core
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] iaddr,
    input  logic [XLEN-1:0] idata,
    output logic [XLEN-1:0] daddr,
    input  logic [XLEN-1:0] drdata,
    output logic [XLEN-1:0] dwdata,
    output logic [3:0]      dwe
);

    logic [31:0] pc_reg, pc_next, pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_y, mem_addr;
    logic [31:0] rd_val, load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        rd_we, load_ok, br_taken, halt;
    logic [3:0]  dwe_c;
    alu_op_t     alu_op;

    assign opcode   = idata[6:0];
    assign funct3   = idata[14:12];
    assign imm_i    = {{20{idata[31]}}, idata[31:20]};
    assign imm_s    = {{20{idata[31]}}, idata[31:25], idata[11:7]};
    assign imm_b    = {{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0};
    assign imm_u    = {idata[31:12], 12'b0};
    assign imm_j    = {{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0};
    assign pc_plus4 = pc_reg + 32'd4;

`ifdef CPU_HALT_ON_ZERO_EN
    logic halted_reg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            halted_reg <= 1'b0;
        else if (idata == 32'h0)
            halted_reg <= 1'b1;
    end
    assign halt = halted_reg || idata == 32'h0;
`else
    assign halt = 1'b0;
`endif

    cpu_regfile rf (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (idata[19:15]),
        .raddr2 (idata[24:20]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (rd_we && !halt),
        .waddr  (idata[11:7]),
        .wdata  (rd_val)
    );

    // bit 30 selects SUB only for register-register ops, SRA for both shift forms
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            F3_ADD:  alu_op = (opcode == OP_OP && idata[30]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = idata[30] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign alu_b    = (opcode == OP_OP) ? rs2_val : imm_i;
    assign alu_y    = alu_exec(alu_op, rs1_val, alu_b);
    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign daddr    = mem_addr;

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = rs1_val == rs2_val;
            F3_BNE:  br_taken = rs1_val != rs2_val;
            F3_BLT:  br_taken = $signed(rs1_val) < $signed(rs2_val);
            F3_BGE:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            F3_BLTU: br_taken = rs1_val < rs2_val;
            F3_BGEU: br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    // misaligned accesses fall onto the aligned lane by ignoring the low bits
    assign ld_byte = drdata[{mem_addr[1:0], 3'b000} +: 8];
    assign ld_half = mem_addr[1] ? drdata[31:16] : drdata[15:0];

    always_comb begin
        load_ok  = 1'b1;
        load_val = drdata;
        case (funct3[1:0])
            SZ_B:    load_val = {{24{~funct3[2] & ld_byte[7]}}, ld_byte};
            SZ_H:    load_val = {{16{~funct3[2] & ld_half[15]}}, ld_half};
            SZ_W:    load_ok  = ~funct3[2];
            default: load_ok  = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = pc_plus4;
        rd_we   = 1'b0;
        rd_val  = alu_y;
        dwe_c   = 4'b0000;
        dwdata  = rs2_val;
        case (opcode)
            OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc_reg + imm_u; end
            OP_JAL:    begin rd_we = 1'b1; rd_val = pc_plus4; pc_next = pc_reg + imm_j; end
            OP_JALR:   begin rd_we = 1'b1; rd_val = pc_plus4; pc_next = {mem_addr[31:1], 1'b0}; end
            OP_BRANCH: if (br_taken) pc_next = pc_reg + imm_b;
            OP_LOAD:   begin rd_we = load_ok; rd_val = load_val; end
            OP_STORE: begin
                if (!funct3[2]) begin
                    case (funct3[1:0])
                        SZ_B: begin
                            dwe_c  = 4'b0001 << mem_addr[1:0];
                            dwdata = {4{rs2_val[7:0]}};
                        end
                        SZ_H: begin
                            dwe_c  = mem_addr[1] ? 4'b1100 : 4'b0011;
                            dwdata = {2{rs2_val[15:0]}};
                        end
                        SZ_W:    dwe_c = 4'b1111;
                        default: dwe_c = 4'b0000;
                    endcase
                end
            end
            OP_IMM, OP_OP:       rd_we = 1'b1;
            OP_FENCE, OP_SYSTEM: rd_we = 1'b0;
            default:             rd_we = 1'b0;
        endcase
        if (halt) begin
            pc_next = pc_reg;
            dwe_c   = 4'b0000;
        end
    end

    assign dwe = reset ? 4'b0000 : dwe_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_reg <= RESET_PC;
        else
            pc_reg <= pc_next;
    end

    assign iaddr = pc_reg;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: runs a hand-assembled program against local
// imem/dmem models and compares memory words and PC against hand-computed values.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iaddr, idata, daddr, drdata, dwdata;
    logic [3:0]  dwe;

    logic [31:0] imem      [0:127];
    logic [31:0] dmem      [0:31];
    logic [31:0] dmem_init [0:31];
    logic        load_dmem;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [0:26];

    always #5 clk = ~clk;

    assign idata  = imem[iaddr[8:2]];
    assign drdata = dmem[daddr[6:2]];

    always @(posedge clk) begin
        if (load_dmem) begin
            for (int k = 0; k < 32; k++) dmem[k] <= dmem_init[k];
        end else begin
            for (int b = 0; b < 4; b++)
                if (dwe[b]) dmem[daddr[6:2]][8*b +: 8] <= dwdata[8*b +: 8];
        end
    end

    cpu_core dut (
        .clk    (clk),
        .reset  (reset),
        .iaddr  (iaddr),
        .idata  (idata),
        .daddr  (daddr),
        .drdata (drdata),
        .dwdata (dwdata),
        .dwe    (dwe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] m, a, f, d, o;
        m = imm; a = rs1; f = f3; d = rd; o = op;
        return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
        logic [31:0] s, b, a, f, d, o;
        s = f7; b = rs2; a = rs1; f = f3; d = rd; o = op;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[11:5], b[4:0], a[4:0], f[2:0], m[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        logic [31:0] m, d, o;
        m = imm20; d = rd; o = op;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 'h13);
    endfunction

    function automatic logic [31:0] sw(int rs2, int off);
        return enc_s(off, rs2, 0, 2);
    endfunction

    initial begin
        logic [31:0] prev_pc, exp_pc;

        vecs = '{
            '{0, 32'h0000_0002}, '{1, 32'h0000_00AB}, '{2, 32'hF800_0000},
            '{3, 32'h0800_0000}, '{4, 32'h0000_0000}, '{5, 32'hFFFF_FFFF},
            '{7, 32'h1122_AB44}, '{8, 32'h01AB_7788}, '{9, 32'h0000_0001},
            '{10, 32'hFFFF_FFAB}, '{11, 32'hFFFF_AB44}, '{12, 32'h0000_AB44},
            '{13, 32'h0000_0001}, '{14, 32'h0000_0007}, '{15, 32'h0000_01AA},
            '{16, 32'hFFFF_FE54}, '{17, 32'h0000_0800}, '{18, 32'h0000_10A0},
            '{19, 32'h0000_0000}, '{20, 32'h0000_00A0}, '{21, 32'h0000_07AB},
            '{22, 32'h1234_5678}, '{23, 32'h0000_00C8}, '{24, 32'hFFFF_FF2A},
            '{25, 32'h0000_0004}, '{26, 32'h0000_010C}, '{6, 32'h0000_0000}
        };

        for (int k = 0; k < 128; k++) imem[k] = 32'h0;
        for (int k = 0; k < 32; k++) dmem_init[k] = 32'h0;
        dmem_init[7]  = 32'h1122_3344;
        dmem_init[8]  = 32'h5566_7788;
        dmem_init[19] = 32'hDEAD_BEEF;
        dmem_init[22] = 32'h1234_5678;
        dmem_init[27] = 32'hAAAA_0001;
        dmem_init[28] = 32'hBBBB_0002;
        dmem_init[29] = 32'hCCCC_0003;

        imem[0]  = addi(1, 0, 5);
        imem[1]  = addi(2, 0, -3);
        imem[2]  = enc_r(0, 2, 1, 0, 3, 'h33);
        imem[3]  = sw(3, 0);
        imem[4]  = addi(1, 0, 'h1AB);
        imem[5]  = enc_s(5, 1, 0, 0);
        imem[6]  = enc_i(5, 0, 4, 4, 3);
        imem[7]  = sw(4, 4);
        imem[8]  = enc_u('h80000, 1, 'h37);
        imem[9]  = enc_i('h404, 1, 5, 2, 'h13);
        imem[10] = enc_i(4, 1, 5, 3, 'h13);
        imem[11] = sw(2, 8);
        imem[12] = sw(3, 12);
        imem[13] = addi(1, 0, -1);
        imem[14] = addi(2, 0, 1);
        imem[15] = enc_b(8, 2, 1, 4);
        imem[16] = sw(2, 16);
        imem[17] = sw(1, 20);
        imem[18] = enc_b(8, 2, 1, 6);
        imem[19] = sw(2, 36);
        imem[20] = addi(5, 0, 'h1AB);
        imem[21] = enc_s(29, 5, 0, 0);
        imem[22] = enc_s(34, 5, 0, 1);
        imem[23] = enc_i(29, 0, 0, 6, 3);
        imem[24] = sw(6, 40);
        imem[25] = enc_i(28, 0, 1, 7, 3);
        imem[26] = sw(7, 44);
        imem[27] = enc_i(28, 0, 5, 8, 3);
        imem[28] = sw(8, 48);
        imem[29] = enc_r(0, 2, 1, 2, 9, 'h33);
        imem[30] = sw(9, 52);
        imem[31] = enc_r(0, 2, 1, 3, 10, 'h33);
        imem[32] = addi(10, 10, 7);
        imem[33] = sw(10, 56);
        imem[34] = enc_r('h20, 2, 5, 0, 11, 'h33);
        imem[35] = sw(11, 60);
        imem[36] = enc_r(0, 1, 5, 4, 12, 'h33);
        imem[37] = sw(12, 64);
        imem[38] = enc_r(0, 5, 2, 1, 13, 'h33);
        imem[39] = sw(13, 68);
        imem[40] = enc_u(1, 14, 'h17);
        imem[41] = sw(14, 72);
        imem[42] = addi(0, 0, 9);
        imem[43] = sw(0, 76);
        imem[44] = 32'h0000_000F;
        imem[45] = enc_i('h700, 5, 6, 15, 'h13);
        imem[46] = enc_i('hF0, 15, 7, 16, 'h13);
        imem[47] = sw(15, 84);
        imem[48] = sw(16, 80);
        imem[49] = enc_j(8, 17);
        imem[50] = sw(0, 88);
        imem[51] = sw(17, 92);
        imem[52] = enc_r('h20, 2, 12, 5, 18, 'h33);
        imem[53] = sw(18, 96);
        imem[54] = addi(20, 0, 0);
        imem[55] = enc_b(8, 2, 2, 0);
        imem[56] = addi(20, 20, 1);
        imem[57] = enc_b(8, 2, 1, 1);
        imem[58] = addi(20, 20, 2);
        imem[59] = enc_b(8, 2, 1, 5);
        imem[60] = addi(20, 20, 4);
        imem[61] = enc_b(8, 2, 1, 7);
        imem[62] = addi(20, 20, 8);
        imem[63] = sw(20, 100);
        imem[64] = enc_u(0, 21, 'h17);
        imem[65] = sw(22, 104);
        imem[66] = enc_i(5, 21, 0, 22, 'h67);

        reset     = 1'b1;
        load_dmem = 1'b1;
        @(negedge clk);
        check("reset_iaddr", iaddr, 32'h0);
        check("reset_dwe", {28'h0, dwe}, 32'h0);
        load_dmem = 1'b0;
        #90;
        reset = 1'b0;
        #1 check("release_iaddr", iaddr, 32'h0);
        @(negedge clk);
        check("first_step_iaddr", iaddr, 32'h4);
        @(negedge clk);
        check("second_step_iaddr", iaddr, 32'h8);

        repeat (100) @(negedge clk);

        // JALR (rs1+5)&~1 must land on 0x104 exactly and alternate with 0x108
        check("loop_pc_in_loop", {31'h0, iaddr == 32'h104 || iaddr == 32'h108}, 32'h1);
        prev_pc = iaddr;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_pc = (prev_pc == 32'h104) ? 32'h108 : 32'h104;
            check("loop_pc", iaddr, exp_pc);
            prev_pc = exp_pc;
        end

        for (int v = 0; v < 27; v++)
            check($sformatf("dmem[%0d]", vecs[v].idx), dmem[vecs[v].idx], vecs[v].exp);

        for (int c = 0; c < 4 && iaddr != 32'h104; c++) @(negedge clk);
        check("loop_sw_iaddr", iaddr, 32'h104);
        check("loop_sw_dwe", {28'h0, dwe}, 32'hF);

        reset = 1'b1;
        #1;
        check("midrun_reset_iaddr", iaddr, 32'h0);
        check("midrun_reset_dwe", {28'h0, dwe}, 32'h0);

        for (int k = 0; k < 128; k++) imem[k] = 32'h0;
        imem[0] = sw(22, 108);
        imem[1] = sw(5, 112);
        imem[2] = 32'h0;
        imem[3] = addi(1, 0, 1);
        imem[4] = sw(1, 116);
        imem[5] = enc_j(0, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        check("regs_cleared_x22", dmem[27], 32'h0);
        check("regs_cleared_x5", dmem[28], 32'h0);
`ifdef CPU_HALT_ON_ZERO_EN
        check("halt_iaddr", iaddr, 32'h8);
        check("halt_dwe", {28'h0, dwe}, 32'h0);
        check("halt_no_store", dmem[29], 32'hCCCC_0003);
`else
        check("zero_nop_iaddr", iaddr, 32'h14);
        check("zero_nop_store", dmem[29], 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
